modbus_req_rx: RTL and testbench

Request-frame receiver for the Modbus RTU slave. It sits directly upstream of the response transmitter. It consumes bytes from the RS-485 UART byte receiver and delimits frames by 3.5-character line silence. It checks CRC-16/Modbus, slave address and function code, then hands a validated Read Holding Registers (0x03) request to the response stage as a start pulse plus decoded fields.

---
 rtl/modbus_req_rx_if.sv | 24 ++
 rtl/modbus_req_rx.sv | 184 ++++++++++++++++++
 tb/tb_modbus_req_rx.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/modbus_req_rx_if.sv
// Byte-receive and request-handoff signals between the UART receiver,
// the Modbus request receiver and the response transmitter.
interface modbus_req_rx_if;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic [7:0]  dev_addr;
    logic        resp_busy;
    logic        tx_start;
    logic [7:0]  func_code;
    logic [15:0] start_addr;
    logic [7:0]  tx_quantity;
    logic        frame_err;
    logic [2:0]  err_code;

    modport master (
        output rx_data, rx_done, dev_addr, resp_busy,
        input  tx_start, func_code, start_addr, tx_quantity, frame_err, err_code
    );

    modport slave (
        input  rx_data, rx_done, dev_addr, resp_busy,
        output tx_start, func_code, start_addr, tx_quantity, frame_err, err_code
    );
endinterface

// File: rtl/modbus_req_rx.sv
// Modbus RTU request-frame receiver: delimits frames by 3.5-char silence,
// checks CRC/address/function/quantity and hands off Read Holding Registers requests.
module modbus_req_rx #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned GAP_CYCLES = (CLK_FREQ / BAUD_RATE) * 39
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    modbus_req_rx_if.slave bus
);

    localparam int unsigned GAP_W     = 20;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned BUF_DEPTH = 8;
    localparam int unsigned IDX_W     = 3;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(BUF_DEPTH + 1);
    localparam logic [15:0]      CRC_INIT = 16'hFFFF;
    localparam logic [7:0]       FC_READ_HOLD = 8'h03;
    localparam logic [15:0]      QTY_MAX  = 16'd125;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_CHECK = 2'd2
    } state_e;

    // One full byte of CRC-16/Modbus (reflected poly 0xA001), LSB first
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                               input logic [7:0]  data);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    state_e           state_q;
    logic [CNT_W-1:0] byte_cnt_q;
    logic [7:0]       byte_q [BUF_DEPTH];
    logic [15:0]      crc_q;
    logic [GAP_W-1:0] gap_q;

    logic             tx_start_q;
    logic             frame_err_q;
    logic [7:0]       func_code_q;
    logic [15:0]      start_addr_q;
    logic [7:0]       tx_quantity_q;
    logic [2:0]       err_code_q;

    logic [15:0]      crc_base_c;
    logic [15:0]      crc_d;
    logic [GAP_W-1:0] gap_d;
    logic [15:0]      quantity_c;
    logic             chk_pass_c;
    logic             chk_err_c;
    logic [2:0]       chk_code_c;

    // A new frame starting in S_IDLE or S_CHECK folds into a fresh CRC
    assign crc_base_c = (state_q == S_RECV) ? crc_q : CRC_INIT;
    assign crc_d      = crc16_byte(crc_base_c, bus.rx_data);

    always_comb begin
        gap_d = gap_q;
        if (bus.rx_done) begin
            gap_d = '0;
        end else if (gap_q != GAP_MAX) begin
            gap_d = gap_q + GAP_W'(1);
        end
    end

    // Frame verdict, first failing check wins; address mismatch is silent
    always_comb begin
        chk_pass_c = 1'b0;
        chk_err_c  = 1'b0;
        chk_code_c = 3'd0;
        quantity_c = {byte_q[4], byte_q[5]};
        if (byte_cnt_q != CNT_FULL) begin
            chk_err_c  = 1'b1;
            chk_code_c = 3'd1;
        end else if (crc_q != 16'h0000) begin
            chk_err_c  = 1'b1;
            chk_code_c = 3'd2;
        end else if ((byte_q[0] != bus.dev_addr) || (byte_q[0] == 8'h00)) begin
            chk_err_c  = 1'b0;
        end else if (byte_q[1] != FC_READ_HOLD) begin
            chk_err_c  = 1'b1;
            chk_code_c = 3'd3;
        end else if ((quantity_c == 16'd0) || (quantity_c > QTY_MAX)) begin
            chk_err_c  = 1'b1;
            chk_code_c = 3'd4;
        end else if (bus.resp_busy) begin
            chk_err_c  = 1'b1;
            chk_code_c = 3'd5;
        end else begin
            chk_pass_c = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= S_IDLE;
            byte_cnt_q    <= '0;
            crc_q         <= CRC_INIT;
            gap_q         <= '0;
            tx_start_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            func_code_q   <= 8'h00;
            start_addr_q  <= 16'h0000;
            tx_quantity_q <= 8'h00;
            err_code_q    <= 3'd0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                byte_q[i] <= 8'h00;
            end
        end else begin
            tx_start_q  <= 1'b0;
            frame_err_q <= 1'b0;
            gap_q       <= gap_d;
            case (state_q)
                S_IDLE: begin
                    if (bus.rx_done) begin
                        byte_q[0]  <= bus.rx_data;
                        byte_cnt_q <= CNT_W'(1);
                        crc_q      <= crc_d;
                        state_q    <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (bus.rx_done) begin
                        if (byte_cnt_q < CNT_FULL) begin
                            byte_q[byte_cnt_q[IDX_W-1:0]] <= bus.rx_data;
                            byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                        end else begin
                            byte_cnt_q <= CNT_OVF;
                        end
                        crc_q <= crc_d;
                    end else if (gap_q == GAP_LAST) begin
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (chk_pass_c) begin
                        tx_start_q    <= 1'b1;
                        func_code_q   <= byte_q[1];
                        start_addr_q  <= {byte_q[2], byte_q[3]};
                        tx_quantity_q <= byte_q[5];
                    end
                    if (chk_err_c) begin
                        frame_err_q <= 1'b1;
                        err_code_q  <= chk_code_c;
                    end
                    // A byte arriving now opens the next frame
                    if (bus.rx_done) begin
                        byte_q[0]  <= bus.rx_data;
                        byte_cnt_q <= CNT_W'(1);
                        crc_q      <= crc_d;
                        state_q    <= S_RECV;
                    end else begin
                        byte_cnt_q <= '0;
                        crc_q      <= CRC_INIT;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    byte_cnt_q <= '0;
                    crc_q      <= CRC_INIT;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_start    = tx_start_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.func_code   = func_code_q;
    assign bus.start_addr  = start_addr_q;
    assign bus.tx_quantity = tx_quantity_q;
    assign bus.err_code    = err_code_q;

endmodule

// File: tb/tb_modbus_req_rx.sv
// Directed bench for modbus_req_rx: frames with hand-known or bench-computed CRCs,
// checking verdicts, output fields and the GAP_CYCLES+1 handoff latency.
module tb_modbus_req_rx;

    localparam int unsigned CLK_FREQ  = 1000000;
    localparam int unsigned BAUD_RATE = 100000;
    localparam int unsigned GAP       = (CLK_FREQ / BAUD_RATE) * 39;
    localparam int          SP        = 110;
    localparam int          LAT       = int'(GAP) + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    modbus_req_rx_if bus();

    modbus_req_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    int n_checks   = 0;
    int n_errors   = 0;
    int tx_pulses  = 0;
    int err_pulses = 0;
    logic [7:0] frm [16];

    always @(negedge clk) begin
        if (bus.tx_start)  tx_pulses  <= tx_pulses + 1;
        if (bus.frame_err) err_pulses <= err_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bit-serial CRC-16/Modbus reference over frm[0..len-1]
    function automatic logic [15:0] crc_ref(input int len);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < len; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ frm[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return c;
    endfunction

    task automatic load_good();
        frm[0] = 8'h11; frm[1] = 8'h03; frm[2] = 8'h00; frm[3] = 8'h6B;
        frm[4] = 8'h00; frm[5] = 8'h03; frm[6] = 8'h76; frm[7] = 8'h87;
    endtask

    task automatic build(input logic [7:0] a, input logic [7:0] f,
                         input logic [15:0] sa, input logic [15:0] q);
        logic [15:0] c;
        frm[0] = a;        frm[1] = f;
        frm[2] = sa[15:8]; frm[3] = sa[7:0];
        frm[4] = q[15:8];  frm[5] = q[7:0];
        c = crc_ref(6);
        frm[6] = c[7:0];   frm[7] = c[15:8];
    endtask

    // sp=0 sends back-to-back bytes; returns at the negedge after the last sampling edge
    task automatic send_frame(input int first, input int len, input int sp);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            bus.rx_data = frm[first + i];
            bus.rx_done = 1'b1;
            if (sp > 0 || i == len - 1) begin
                @(negedge clk);
                bus.rx_done = 1'b0;
                if (i != len - 1) repeat (sp - 1) @(negedge clk);
            end
        end
    endtask

    task automatic wait_result(output bit saw, output int lat);
        saw = 1'b0;
        lat = 0;
        for (int n = 1; n <= LAT + 40; n++) begin
            @(negedge clk);
            if (bus.tx_start || bus.frame_err) begin
                saw = 1'b1;
                lat = n;
                break;
            end
        end
    endtask

    task automatic expect_accept(input string tag);
        bit saw;
        int lat;
        wait_result(saw, lat);
        check({tag, "_seen"}, 32'(saw), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(LAT));
        check({tag, "_tx"}, 32'(bus.tx_start), 32'd1);
        check({tag, "_ferr"}, 32'(bus.frame_err), 32'd0);
        @(negedge clk);
        check({tag, "_tx_1cyc"}, 32'(bus.tx_start), 32'd0);
    endtask

    task automatic expect_reject(input string tag, input logic [2:0] code);
        bit saw;
        int lat;
        wait_result(saw, lat);
        check({tag, "_seen"}, 32'(saw), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(LAT));
        check({tag, "_ferr"}, 32'(bus.frame_err), 32'd1);
        check({tag, "_tx"}, 32'(bus.tx_start), 32'd0);
        check({tag, "_code"}, 32'(bus.err_code), 32'(code));
        @(negedge clk);
        check({tag, "_ferr_1cyc"}, 32'(bus.frame_err), 32'd0);
    endtask

    task automatic expect_silent(input string tag);
        bit saw;
        int lat;
        wait_result(saw, lat);
        check({tag, "_silent"}, 32'(saw), 32'd0);
    endtask

    task automatic check_fields(input string tag, input logic [7:0] fc,
                                input logic [15:0] sa, input logic [7:0] q);
        check({tag, "_func"}, 32'(bus.func_code), 32'(fc));
        check({tag, "_saddr"}, 32'(bus.start_addr), 32'(sa));
        check({tag, "_qty"}, 32'(bus.tx_quantity), 32'(q));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tx0;
        int er0;
        bus.rx_data   = 8'h00;
        bus.rx_done   = 1'b0;
        bus.dev_addr  = 8'h11;
        bus.resp_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(bus.tx_start), 32'd0);
        check("rst_ferr", 32'(bus.frame_err), 32'd0);
        check("rst_code", 32'(bus.err_code), 32'd0);
        check_fields("rst", 8'h00, 16'h0000, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        load_good();
        send_frame(0, 8, SP);
        expect_accept("good");
        check_fields("good", 8'h03, 16'h006B, 8'h03);

        frm[7] = 8'h88;
        send_frame(0, 8, SP);
        expect_reject("badcrc", 3'd2);
        check_fields("badcrc_hold", 8'h03, 16'h006B, 8'h03);

        load_good();
        bus.dev_addr = 8'h12;
        send_frame(0, 8, SP);
        expect_silent("otheraddr");
        check("otheraddr_code", 32'(bus.err_code), 32'd2);
        bus.dev_addr = 8'h11;

        frm[8] = 8'h00;
        send_frame(0, 9, SP);
        expect_reject("nine", 3'd1);

        send_frame(0, 4, SP);
        expect_reject("split_a", 3'd1);
        send_frame(4, 4, SP);
        expect_reject("split_b", 3'd1);

        build(8'h11, 8'h03, 16'h0000, 16'h0000);
        send_frame(0, 8, SP);
        expect_reject("qty0", 3'd4);

        build(8'h11, 8'h06, 16'h0001, 16'h0003);
        send_frame(0, 8, SP);
        expect_reject("func06", 3'd3);

        build(8'h11, 8'h03, 16'h0000, 16'h007E);
        send_frame(0, 8, SP);
        expect_reject("qty126", 3'd4);

        build(8'h11, 8'h03, 16'h0000, 16'h0101);
        send_frame(0, 8, SP);
        expect_reject("qtyhi", 3'd4);

        build(8'h11, 8'h03, 16'h1234, 16'h007D);
        send_frame(0, 8, SP);
        expect_accept("qty125");
        check_fields("qty125", 8'h03, 16'h1234, 8'h7D);

        load_good();
        bus.resp_busy = 1'b1;
        send_frame(0, 8, SP);
        expect_reject("busy", 3'd5);
        check_fields("busy_hold", 8'h03, 16'h1234, 8'h7D);
        bus.resp_busy = 1'b0;

        send_frame(0, 8, 0);
        expect_accept("b2b");
        check_fields("b2b", 8'h03, 16'h006B, 8'h03);

        // Byte lands on the very edge the gap would expire: frame continues
        build(8'h11, 8'h03, 16'h0A0B, 16'h0005);
        #1 tx0 = tx_pulses; er0 = err_pulses;
        send_frame(0, 4, SP);
        repeat (GAP - 2) @(negedge clk);
        send_frame(4, 4, SP);
        expect_accept("gapedge");
        check_fields("gapedge", 8'h03, 16'h0A0B, 8'h05);
        #1 check("gapedge_errs", 32'(err_pulses - er0), 32'd0);

        // Next frame starts on the S_CHECK cycle of the previous one
        load_good();
        #1 tx0 = tx_pulses; er0 = err_pulses;
        send_frame(0, 8, SP);
        build(8'h11, 8'h03, 16'h4321, 16'h0010);
        repeat (GAP - 1) @(negedge clk);
        send_frame(0, 8, SP);
        expect_accept("inchk");
        check_fields("inchk", 8'h03, 16'h4321, 8'h10);
        #1;
        check("inchk_txcnt", 32'(tx_pulses - tx0), 32'd2);
        check("inchk_errcnt", 32'(err_pulses - er0), 32'd0);

        load_good();
        #1 tx0 = tx_pulses; er0 = err_pulses;
        send_frame(0, 4, SP);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        expect_silent("midrst");
        check_fields("midrst", 8'h00, 16'h0000, 8'h00);
        check("midrst_code", 32'(bus.err_code), 32'd0);
        #1;
        check("midrst_txcnt", 32'(tx_pulses - tx0), 32'd0);
        check("midrst_errcnt", 32'(err_pulses - er0), 32'd0);
        send_frame(0, 8, SP);
        expect_accept("postrst");
        check_fields("postrst", 8'h03, 16'h006B, 8'h03);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
